cmd_responder: RTL and testbench

//  Responder end of the remote command link. Sits behind UART_wrapper on the robot side.

---
 rtl/cmd_responder.sv | 136 +++++++++++++
 tb/tb_cmd_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_responder.sv
`default_nettype none
// ============================================================================
// cmd_responder : accepts UART commands, dispatches legal opcodes to the
//                 executor and returns a one-byte ACK/NAK/TMO status.
// Rev 1.0
// ============================================================================
module cmd_responder #(
    parameter logic [15:0] OP_MASK  = 16'h00FF,
    parameter logic [7:0]  ACK_BYTE = 8'hA5,
    parameter logic [7:0]  NAK_BYTE = 8'hEE,
    parameter logic [7:0]  TMO_BYTE = 8'hDD,
    parameter int          TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [15:0] cmd,
    output logic        clr_cmd_rdy,
    output logic        op_vld,
    output logic [3:0]  opcode,
    output logic [11:0] operand,
    input  logic        op_done,
    output logic        trmt,
    output logic [7:0]  resp,
    input  logic        tx_done,
    output logic        busy
);

    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        SEND    = 2'd2,
        WAIT_TX = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [11:0]   operand_q, operand_d;
    logic [7:0]    resp_q, resp_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          clr_q, clr_d;
    logic          vld_q, vld_d;
    logic          trmt_q, trmt_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        resp_d    = resp_q;
        timer_d   = timer_q;
        clr_d     = 1'b0;
        vld_d     = 1'b0;
        trmt_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    opcode_d  = cmd[15:12];
                    operand_d = cmd[11:0];
                    clr_d     = 1'b1;
                    if (OP_MASK[cmd[15:12]]) begin
                        vld_d   = 1'b1;
                        timer_d = '0;
                        state_d = EXEC;
                    end else begin
                        resp_d  = NAK_BYTE;
                        state_d = SEND;
                    end
                end
            end
            EXEC: begin
                // A completion in the deadline cycle still counts as success
                if (op_done) begin
                    resp_d  = ACK_BYTE;
                    state_d = SEND;
                end else if (timer_q == TMO_LAST) begin
                    resp_d  = TMO_BYTE;
                    state_d = SEND;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SEND: begin
                trmt_d  = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            resp_q    <= '0;
            timer_q   <= '0;
            clr_q     <= 1'b0;
            vld_q     <= 1'b0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            resp_q    <= resp_d;
            timer_q   <= timer_d;
            clr_q     <= clr_d;
            vld_q     <= vld_d;
            trmt_q    <= trmt_d;
            busy_q    <= busy_d;
        end
    end

    assign clr_cmd_rdy = clr_q;
    assign op_vld      = vld_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign trmt        = trmt_q;
    assign resp        = resp_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_responder.sv
`default_nettype none
// Testbench for cmd_responder: table vectors, hand-written corner sequences
// and random commands checked against a transaction-level model.
module tb_cmd_responder;

    localparam int TO     = 20;
    localparam int TX_DLY = 2;
    localparam int INF    = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [15:0] cmd = '0;
    logic        op_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        clr_cmd_rdy, op_vld, trmt, busy;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic [7:0]  resp;

    cmd_responder #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .clr_cmd_rdy(clr_cmd_rdy), .op_vld(op_vld), .opcode(opcode),
        .operand(operand), .op_done(op_done), .trmt(trmt), .resp(resp),
        .tx_done(tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int n_clr = 0, n_vld = 0, n_trmt = 0;
    int clr_cyc = 0, vld_cyc = 0, trmt_cyc = 0;
    int done_dly = -1, done_at = -1, tx_at = INF;
    bit tx_hold = 1'b0;
    logic [7:0] resp_log[$];

    typedef struct {
        logic [15:0] c;
        int          d;
        logic [7:0]  r;
        int          v;
        int          lat;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of the surrounding world: UART_wrapper, executor, transmitter.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tx_done && !busy) tx_done = 1'b0;
        if (clr_cmd_rdy) begin
            n_clr++;
            clr_cyc = cyc;
            cmd_rdy = 1'b0;
        end
        if (op_vld) begin
            n_vld++;
            vld_cyc = cyc;
            done_at = (done_dly >= 0) ? cyc + done_dly : -1;
        end
        op_done = (cyc == done_at);
        if (trmt) begin
            n_trmt++;
            trmt_cyc = cyc;
            resp_log.push_back(resp);
            tx_at = cyc + TX_DLY;
        end
        if (!tx_hold && cyc >= tx_at) begin
            tx_done = 1'b1;
            tx_at = INF;
        end
    endtask

    // Expected outcome of one command from the status-byte rules.
    function automatic void model(input logic [15:0] c, input int d,
                                  output logic [7:0] r, output int v, output int lat);
        logic [15:0] m;
        m = 16'h00FF;
        if (!m[c[15:12]]) begin
            r = 8'hEE; v = 0; lat = 2;
        end else if (d >= 0 && d < TO) begin
            r = 8'hA5; v = 1; lat = 3 + d;
        end else begin
            r = 8'hDD; v = 1; lat = TO + 2;
        end
    endfunction

    task automatic run_cmd(input logic [15:0] c, input int d, output int start);
        int  b_trmt;
        bit  fin;
        b_trmt   = n_trmt;
        fin      = 1'b0;
        done_dly = d;
        cmd      = c;
        cmd_rdy  = 1'b1;
        start    = cyc;
        for (int i = 0; i < TO + 40 && !fin; i++) begin
            tick();
            if (n_trmt > b_trmt && !busy) fin = 1'b1;
        end
        if (!fin) check("txn_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_txn(input logic [15:0] c, input int d, input logic [7:0] er,
                             input int ev, input int elat);
        int b_clr, b_vld, b_trmt, start;
        b_clr  = n_clr;
        b_vld  = n_vld;
        b_trmt = n_trmt;
        run_cmd(c, d, start);
        check("clr_count", n_clr - b_clr, 1);
        check("clr_latency", clr_cyc - start, 1);
        check("vld_count", n_vld - b_vld, ev);
        if (ev == 1) check("vld_with_clr", vld_cyc, clr_cyc);
        check("trmt_count", n_trmt - b_trmt, 1);
        check("trmt_latency", trmt_cyc - start, elat);
        check("resp_at_trmt", resp_log[$], er);
        check("resp_held", resp, er);
        check("opcode", opcode, c[15:12]);
        check("operand", operand, c[11:0]);
        check("busy_end", busy, 0);
    endtask

    initial begin
        int         s, b_trmt, b_clr, b_vld, d, v, lat;
        logic [15:0] c;
        logic [7:0]  r;
        bit          got;

        tbl[0] = '{16'h4F53,  5, 8'hA5, 1,  8};
        tbl[1] = '{16'hC123,  0, 8'hEE, 0,  2};
        tbl[2] = '{16'h0000,  0, 8'hA5, 1,  3};
        tbl[3] = '{16'h7FFF, 19, 8'hA5, 1, 22};
        tbl[4] = '{16'h2ABC, -1, 8'hDD, 1, 22};
        tbl[5] = '{16'h8001,  3, 8'hEE, 0,  2};
        tbl[6] = '{16'hF000, -1, 8'hEE, 0,  2};
        tbl[7] = '{16'h1234, 18, 8'hA5, 1, 21};

        // Reset with a command waiting
        cmd     = 16'h4F53;
        cmd_rdy = 1'b1;
        repeat (4) tick();
        check("rst_clr", clr_cmd_rdy, 0);
        check("rst_vld", op_vld, 0);
        check("rst_trmt", trmt, 0);
        check("rst_busy", busy, 0);
        check("rst_opcode", opcode, 0);
        check("rst_operand", operand, 0);
        check("rst_resp", resp, 0);
        check("rst_no_clr", n_clr, 0);
        cmd_rdy = 1'b0;
        rst_n   = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 8; i++)
            check_txn(tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].v, tbl[i].lat);

        // Timeout, then a late op_done must be ignored
        check_txn(16'h6321, -1, 8'hDD, 1, TO + 2);
        b_trmt  = n_trmt;
        b_vld   = n_vld;
        done_at = cyc + 1;
        repeat (4) tick();
        check("late_done_trmt", n_trmt, b_trmt);
        check("late_done_vld", n_vld, b_vld);
        check("late_done_busy", busy, 0);
        check("late_done_resp", resp, 8'hDD);

        // Second command arrives while waiting on the transmitter
        b_clr   = n_clr;
        b_trmt  = n_trmt;
        tx_hold = 1'b1;
        done_dly = -1;
        cmd     = 16'hC000;
        cmd_rdy = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (n_trmt > b_trmt) got = 1'b1;
        end
        check("q_first_trmt", got, 1);
        cmd      = 16'h3456;
        cmd_rdy  = 1'b1;
        done_dly = 2;
        repeat (6) tick();
        check("q_not_cleared", n_clr - b_clr, 1);
        check("q_rdy_pending", cmd_rdy, 1);
        check("q_busy_wait", busy, 1);
        tx_hold = 1'b0;
        got     = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (n_trmt == b_trmt + 2 && !busy) got = 1'b1;
        end
        check("q_second_done", got, 1);
        check("q_trmt_total", n_trmt - b_trmt, 2);
        check("q_clr_total", n_clr - b_clr, 2);
        check("q_resp_first", resp_log[resp_log.size() - 2], 8'hEE);
        check("q_resp_second", resp_log[resp_log.size() - 1], 8'hA5);
        check("q_opcode", opcode, 4'h3);

        // Reset in the middle of EXEC
        b_trmt   = n_trmt;
        done_dly = -1;
        cmd      = 16'h5ABC;
        cmd_rdy  = 1'b1;
        repeat (5) tick();
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_resp", resp, 0);
        check("mid_rst_opcode", opcode, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (TO + 5) tick();
        check("mid_rst_no_trmt", n_trmt, b_trmt);
        check("mid_rst_idle", busy, 0);
        check_txn(16'h4F53, 5, 8'hA5, 1, 8);

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            c = 16'($urandom);
            d = int'($urandom_range(0, 22));
            if (d > 20) d = -1;
            model(c, d, r, v, lat);
            check_txn(c, d, r, v, lat);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
